bb_integrate_dump: RTL and testbench
====================================

BB_INTEGRATE_DUMP -- requirements
Module: bb_integrate_dump

Interface
REQ-001 SHALL have parameter DECIM, default 4: demod samples summed per output chip; legal range 2..16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries, fixed at 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port demod_rdy, input, 1 bit: I_BB/Q_BB sample valid strobe from the demodulator.
REQ-006 SHALL have port I_BB, input, 9 bits: baseband in-phase sample, two's complement.
REQ-007 SHALL have port Q_BB, input, 9 bits: baseband quadrature sample, two's complement.
REQ-008 SHALL have port sync_clr, input, 1 bit: restarts chip accumulation (chip-phase realignment from downstream sync).
REQ-009 SHALL have port I_CHIP, output, 13 bits: integrated in-phase chip value, two's complement.
REQ-010 SHALL have port Q_CHIP, output, 13 bits: integrated quadrature chip value, two's complement.
REQ-011 SHALL have port chip_valid, output, 1 bit: FIFO head holds a chip.
REQ-012 SHALL have port chip_ready, input, 1 bit: consumer accepts head when chip_valid and chip_ready are both high.
REQ-013 SHALL have port overflow, output, 1 bit: sticky, set when a chip is dropped.

Function
REQ-014 SHALL implement FSM states IDLE and ACCUM: IDLE->ACCUM on the first demod_rdy; ACCUM->IDLE only on reset.
REQ-015 SHALL sign-extend I_BB and Q_BB to 13 bits before accumulating; no saturation or truncation (16*256 fits).
REQ-016 SHALL keep a sample counter cnt, range 0..DECIM-1, incremented on each accepted demod_rdy.
REQ-017 SHALL, on the sample where cnt==DECIM-1, push (acc_I+I_BB, acc_Q+Q_BB) to the FIFO, clear both accumulators and set cnt=0 (dump).
REQ-018 SHALL, otherwise, add the sample into the accumulators on demod_rdy and hold them when demod_rdy is low.
REQ-019 SHALL, on sync_clr without demod_rdy, set the accumulators to 0 and cnt to 0; the partial sum is discarded.
REQ-020 SHALL, on sync_clr with demod_rdy in the same cycle, load the accumulators with that sample and set cnt=1; no dump occurs.
REQ-021 SHALL present a pushed chip at I_CHIP/Q_CHIP with chip_valid high on the cycle after the dump (latency 1) if the FIFO was empty.
REQ-022 SHALL hold I_CHIP, Q_CHIP and chip_valid stable while chip_valid is high and chip_ready is low.
REQ-023 SHALL keep FIFO order first-in first-out.
REQ-024 SHALL, on a dump with the FIFO full and no pop, drop the new chip, keep FIFO contents and set overflow.
REQ-025 SHALL, on a dump with the FIFO full and a pop in the same cycle, accept the push; overflow is not set.
REQ-026 SHALL, on push and pop in the same cycle with the FIFO non-full, keep the occupancy unchanged.
REQ-027 SHALL ignore chip_ready while chip_valid is low.

Reset
REQ-028 SHALL, on reset high at a clock edge, set state=IDLE, cnt=0, accumulators=0, FIFO empty, chip_valid=0, I_CHIP=0, Q_CHIP=0, overflow=0.
REQ-029 SHALL, on reset asserted mid-accumulation or with chips buffered, discard all pending data; no chip is output after reset.
REQ-030 SHALL give reset priority over demod_rdy, sync_clr and chip_ready.

Structure
REQ-031 SHALL place DECIM default, ACC_W=13, BB_W=9 and the state enum (IDLE, ACCUM) in shared package bb_pkg.
REQ-032 SHALL implement the buffer as sub-module chip_fifo: 2 entries, 26-bit payload, valid/ready, full/empty flags.

Verification
REQ-033 SHALL check: DECIM=4, I_BB=Q_BB=+10 on 4 consecutive demod_rdy, chip_ready=1 -> I_CHIP=Q_CHIP=40, chip_valid for 1 cycle, 1 cycle after the 4th sample.
REQ-034 SHALL check: DECIM=16, I_BB=-256 and Q_BB=+255 for 16 samples -> I_CHIP=-4096, Q_CHIP=+4080, no wrap.
REQ-035 SHALL check: 2 samples of +5, then sync_clr with a demod_rdy of +3, then 3 more samples of +1 -> I_CHIP=6.
REQ-036 SHALL check: chip_ready=0 while 3 chips are produced -> first 2 retained in order, third dropped, overflow=1 and stays high until reset.
REQ-037 SHALL check: FIFO full with chip_ready=1 on the dump cycle -> push accepted, overflow=0.
REQ-038 SHALL check: reset after 2 of 4 samples with 1 chip buffered -> chip_valid=0 next cycle; a fresh 4 samples of +1 -> I_CHIP=4.

Source files
------------

// File: rtl/bb_pkg.sv
// -----------------------------------------------------------------------------
// bb_pkg
// Shared definitions for the baseband integrate-and-dump block.
//   BB_W          : width of the demodulator I/Q samples (two's complement)
//   ACC_W         : width of the chip accumulators and chip outputs
//   DECIM_DEFAULT : default number of samples integrated per chip
//   DECIM_MAX     : largest supported decimation (sizes the sample counter)
//   state_t       : integrator FSM states
//   chip_t        : one integrated I/Q chip, as stored in the output FIFO
//   sext_bb()     : sign-extends one sample to accumulator width
// -----------------------------------------------------------------------------
package bb_pkg;

    localparam int BB_W          = 9;
    localparam int ACC_W         = 13;
    localparam int DECIM_DEFAULT = 4;
    localparam int DECIM_MAX     = 16;
    localparam int CNT_W         = $clog2(DECIM_MAX);
    localparam int CHIP_W        = 2 * ACC_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] i;
        logic signed [ACC_W-1:0] q;
    } chip_t;

    // 16 samples of -256 sum to -4096, which is exactly the 13-bit minimum,
    // so widening to ACC_W is all that is needed; no saturation logic.
    function automatic logic signed [ACC_W-1:0] sext_bb(input logic [BB_W-1:0] x);
        return {{(ACC_W-BB_W){x[BB_W-1]}}, x};
    endfunction

endpackage

// File: rtl/chip_fifo.sv
// -----------------------------------------------------------------------------
// chip_fifo
// Small synchronous FIFO holding integrated chips until the consumer takes them.
// The head entry is presented combinationally from storage.
//   clk, reset  : clock and synchronous active-high reset
//   push_valid  : write push_data this cycle (accepted if not full, or if a pop
//                 happens in the same cycle)
//   push_data   : entry to write
//   pop_ready   : consumer takes the head entry (ignored while empty)
//   pop_data    : head entry
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module chip_fifo
    import bb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = CHIP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == OCC_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop_ready && !empty;
    // When full, a simultaneous pop frees the slot the write pointer already
    // points at, so the push can land in the same cycle.
    assign do_push  = push_valid && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset too (only DEPTH words) so the head, and
            // hence the chip outputs, read zero straight after reset.
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/bb_integrate_dump.sv
// -----------------------------------------------------------------------------
// bb_integrate_dump
// Integrates DECIM consecutive demodulator samples into one I/Q chip and queues
// the chips in a 2-entry FIFO for the downstream consumer.
//   clk, reset  : clock and synchronous active-high reset (highest priority)
//   demod_rdy   : I_BB/Q_BB valid strobe
//   I_BB, Q_BB  : 9-bit two's complement baseband samples
//   sync_clr    : restart chip accumulation (chip-phase realignment); a sample
//                 arriving with it becomes the first sample of the new chip
//   I_CHIP, Q_CHIP : 13-bit integrated chip at the FIFO head
//   chip_valid  : FIFO head holds a chip
//   chip_ready  : consumer takes the head when chip_valid is also high
//   overflow    : sticky; set when a chip is dropped because the FIFO was full
// DECIM must lie in 2..16; FIFO_DEPTH is expected to stay at 2.
// -----------------------------------------------------------------------------
module bb_integrate_dump
    import bb_pkg::*;
#(
    parameter int DECIM      = DECIM_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              demod_rdy,
    input  logic [BB_W-1:0]   I_BB,
    input  logic [BB_W-1:0]   Q_BB,
    input  logic              sync_clr,
    output logic [ACC_W-1:0]  I_CHIP,
    output logic [ACC_W-1:0]  Q_CHIP,
    output logic              chip_valid,
    input  logic              chip_ready,
    output logic              overflow
);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic signed [ACC_W-1:0] acc_i, acc_i_next;
    logic signed [ACC_W-1:0] acc_q, acc_q_next;
    logic signed [ACC_W-1:0] sample_i, sample_q;
    logic                    dump;
    chip_t                   dump_chip;
    chip_t                   head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    chip_pop;

    assign sample_i = sext_bb(I_BB);
    assign sample_q = sext_bb(Q_BB);

    // ---------------------------------------------------------------------
    // Integrator state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            acc_i <= acc_i_next;
            acc_q <= acc_q_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and dump decision
    // ---------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        acc_i_next  = acc_i;
        acc_q_next  = acc_q;
        dump        = 1'b0;
        dump_chip.i = acc_i + sample_i;
        dump_chip.q = acc_q + sample_q;

        // IDLE only marks "no sample seen since reset"; once a sample arrives
        // the integrator stays in ACCUM until the next reset.
        unique case (state)
            IDLE:    if (demod_rdy) state_next = ACCUM;
            ACCUM:   state_next = ACCUM;
            default: state_next = IDLE;
        endcase

        if (sync_clr) begin
            // Realignment discards the partial chip; a coincident sample
            // starts the new chip rather than completing the old one.
            if (demod_rdy) begin
                acc_i_next = sample_i;
                acc_q_next = sample_q;
                cnt_next   = CNT_W'(1);
            end else begin
                acc_i_next = '0;
                acc_q_next = '0;
                cnt_next   = '0;
            end
        end else if (demod_rdy) begin
            if (cnt == CNT_W'(DECIM - 1)) begin
                dump       = 1'b1;
                acc_i_next = '0;
                acc_q_next = '0;
                cnt_next   = '0;
            end else begin
                acc_i_next = acc_i + sample_i;
                acc_q_next = acc_q + sample_q;
                cnt_next   = cnt + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output buffer
    // ---------------------------------------------------------------------
    chip_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CHIP_W)
    ) u_chip_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (dump),
        .push_data  (dump_chip),
        .pop_ready  (chip_ready),
        .pop_data   (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign chip_valid = !fifo_empty;
    assign chip_pop   = chip_valid && chip_ready;
    assign I_CHIP     = head.i;
    assign Q_CHIP     = head.q;

    // A chip is lost only when the FIFO is full and nothing leaves this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (dump && fifo_full && !chip_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bb_integrate_dump.sv
// -----------------------------------------------------------------------------
// tb_bb_integrate_dump
// Two instances (DECIM=4 and DECIM=16) share one stimulus stream. A behavioural
// model per instance sums samples per chip and tracks buffer occupancy; accepted
// chips go into an expected queue that a negedge monitor pops on handshakes.
// -----------------------------------------------------------------------------
module tb_bb_integrate_dump;
    import bb_pkg::*;

    localparam int MODEL_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        demod_rdy;
    logic [8:0]  I_BB;
    logic [8:0]  Q_BB;
    logic        sync_clr;
    logic        chip_ready;

    logic [12:0] i_chip4, q_chip4, i_chip16, q_chip16;
    logic        cv4, cv16, ovf4, ovf16;

    always #5 clk = ~clk;

    bb_integrate_dump #(.DECIM(4), .FIFO_DEPTH(2)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .demod_rdy  (demod_rdy),
        .I_BB       (I_BB),
        .Q_BB       (Q_BB),
        .sync_clr   (sync_clr),
        .I_CHIP     (i_chip4),
        .Q_CHIP     (q_chip4),
        .chip_valid (cv4),
        .chip_ready (chip_ready),
        .overflow   (ovf4)
    );

    bb_integrate_dump #(.DECIM(16), .FIFO_DEPTH(2)) dut16 (
        .clk        (clk),
        .reset      (reset),
        .demod_rdy  (demod_rdy),
        .I_BB       (I_BB),
        .Q_BB       (Q_BB),
        .sync_clr   (sync_clr),
        .I_CHIP     (i_chip16),
        .Q_CHIP     (q_chip16),
        .chip_valid (cv16),
        .chip_ready (chip_ready),
        .overflow   (ovf16)
    );

    typedef struct {
        int i;
        int q;
    } chip_s;

    chip_s exp0[$];
    chip_s exp1[$];
    int    psum_i[2];
    int    psum_q[2];
    int    pn[2];
    int    occ[2];
    bit    ovf_m[2];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge, using the inputs held across it.
    task automatic model_edge(input int d, input int decim);
        bit    pop;
        bit    have_chip;
        chip_s c;
        int    si, sq;
        si = int'($signed(I_BB));
        sq = int'($signed(Q_BB));
        if (reset) begin
            psum_i[d] = 0; psum_q[d] = 0; pn[d] = 0; occ[d] = 0; ovf_m[d] = 1'b0;
            if (d == 0) exp0.delete(); else exp1.delete();
            return;
        end
        pop       = chip_ready && (occ[d] > 0);
        have_chip = 1'b0;
        if (sync_clr) begin
            psum_i[d] = demod_rdy ? si : 0;
            psum_q[d] = demod_rdy ? sq : 0;
            pn[d]     = demod_rdy ? 1 : 0;
        end else if (demod_rdy) begin
            psum_i[d] += si;
            psum_q[d] += sq;
            pn[d]++;
            if (pn[d] == decim) begin
                c.i = psum_i[d];
                c.q = psum_q[d];
                have_chip = 1'b1;
                psum_i[d] = 0; psum_q[d] = 0; pn[d] = 0;
            end
        end
        if (have_chip) begin
            if (occ[d] < MODEL_DEPTH || pop) begin
                if (d == 0) exp0.push_back(c); else exp1.push_back(c);
                occ[d]++;
            end else begin
                ovf_m[d] = 1'b1;
            end
        end
        if (pop) occ[d]--;
    endtask

    task automatic mon(input int d);
        logic  v, ov;
        int    ai, aq, qsize;
        chip_s e;
        if (d == 0) begin
            v = cv4; ov = ovf4;
            ai = int'($signed(i_chip4)); aq = int'($signed(q_chip4));
            qsize = exp0.size();
        end else begin
            v = cv16; ov = ovf16;
            ai = int'($signed(i_chip16)); aq = int'($signed(q_chip16));
            qsize = exp1.size();
        end
        check($sformatf("chip_valid[d%0d]", d), int'(v), int'(occ[d] != 0));
        check($sformatf("overflow[d%0d]", d), int'(ov), int'(ovf_m[d]));
        if (v) begin
            if (qsize == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_chip[d%0d]: got I=%0d Q=%0d expected none", d, ai, aq);
            end else begin
                e = (d == 0) ? exp0[0] : exp1[0];
                check($sformatf("I_CHIP[d%0d]", d), ai, e.i);
                check($sformatf("Q_CHIP[d%0d]", d), aq, e.q);
                if (chip_ready) begin
                    if (d == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon(0);
                mon(1);
            end
        end
    end

    // Drives one cycle of inputs, lets the edge happen, updates the model and
    // returns 1 time unit after the edge (where directed checks are made).
    task automatic cycle(input bit rst, input bit rdy, input int i, input int q,
                         input bit clr, input bit rdyc);
        reset      = rst;
        demod_rdy  = rdy;
        I_BB       = 9'(i);
        Q_BB       = 9'(q);
        sync_clr   = clr;
        chip_ready = rdyc;
        @(posedge clk);
        model_edge(0, 4);
        model_edge(1, 16);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic samples(input int n, input int i, input int q, input bit rdyc);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, i, q, 1'b0, rdyc);
    endtask

    task automatic idle(input int n, input bit rdyc);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0, 1'b0, rdyc);
    endtask

    initial begin
        int ri, rq;
        bit rr, rd, rc, ry;

        // Reset state
        do_reset();
        check("reset_valid4", int'(cv4), 0);
        check("reset_valid16", int'(cv16), 0);
        check("reset_I4", int'($signed(i_chip4)), 0);
        check("reset_Q4", int'($signed(q_chip4)), 0);
        check("reset_ovf4", int'(ovf4), 0);
        check("reset_ovf16", int'(ovf16), 0);
        mon_en = 1'b1;

        // Four samples of +10 -> 40, valid for exactly one cycle
        samples(3, 10, 10, 1'b1);
        check("d4_no_early_valid", int'(cv4), 0);
        samples(1, 10, 10, 1'b1);
        check("d4_valid_after_4th", int'(cv4), 1);
        check("d4_I40", int'($signed(i_chip4)), 40);
        check("d4_Q40", int'($signed(q_chip4)), 40);
        idle(1, 1'b1);
        check("d4_valid_one_cycle", int'(cv4), 0);

        // DECIM=16 at the extremes: no wrap
        do_reset();
        samples(15, -256, 255, 1'b1);
        check("d16_no_early_valid", int'(cv16), 0);
        samples(1, -256, 255, 1'b1);
        check("d16_valid", int'(cv16), 1);
        check("d16_I_min", int'($signed(i_chip16)), -4096);
        check("d16_Q_max", int'($signed(q_chip16)), 4080);

        // sync_clr with a coincident sample restarts the chip at cnt=1
        do_reset();
        samples(2, 5, 5, 1'b1);
        cycle(1'b0, 1'b1, 3, 3, 1'b1, 1'b1);
        check("clr_no_dump", int'(cv4), 0);
        samples(2, 1, 1, 1'b1);
        check("clr_not_yet", int'(cv4), 0);
        samples(1, 1, 1, 1'b1);
        check("clr_valid", int'(cv4), 1);
        check("clr_I6", int'($signed(i_chip4)), 6);

        // Three chips with no consumer: third dropped, overflow sticky
        do_reset();
        samples(4, 1, 1, 1'b0);
        samples(4, 2, 2, 1'b0);
        samples(4, 3, 3, 1'b0);
        check("ovf_set", int'(ovf4), 1);
        check("ovf_head_first", int'($signed(i_chip4)), 4);
        idle(5, 1'b0);
        check("ovf_hold_valid", int'(cv4), 1);
        check("ovf_hold_head", int'($signed(i_chip4)), 4);
        idle(3, 1'b1);
        check("ovf_drained", int'(cv4), 0);
        check("ovf_sticky", int'(ovf4), 1);

        // Full FIFO with a pop on the dump cycle: push accepted
        do_reset();
        samples(4, 1, 1, 1'b0);
        samples(4, 2, 2, 1'b0);
        samples(3, 3, 3, 1'b0);
        samples(1, 3, 3, 1'b1);
        check("full_pop_no_ovf", int'(ovf4), 0);
        check("full_pop_head", int'($signed(i_chip4)), 8);
        idle(3, 1'b1);
        check("full_pop_drained", int'(cv4), 0);

        // Reset with a chip buffered and a partial chip in progress
        do_reset();
        samples(4, 1, 1, 1'b0);
        samples(2, 1, 1, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("rst_flush_valid", int'(cv4), 0);
        check("rst_flush_I", int'($signed(i_chip4)), 0);
        samples(3, 1, 1, 1'b1);
        check("rst_fresh_not_yet", int'(cv4), 0);
        samples(1, 1, 1, 1'b1);
        check("rst_fresh_valid", int'(cv4), 1);
        check("rst_fresh_I4", int'($signed(i_chip4)), 4);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rr = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 9) < 7);
            rc = ($urandom_range(0, 29) == 0);
            ry = ($urandom_range(0, 9) < 6);
            ri = int'($urandom_range(0, 511)) - 256;
            rq = int'($urandom_range(0, 511)) - 256;
            cycle(rr, rd, ri, rq, rc, ry);
        end
        idle(4, 1'b1);
        check("drain_exp0_empty", exp0.size(), 0);
        check("drain_exp1_empty", exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
